alu_sequencer: RTL and testbench

//  Front-end controller owning the 8-bit ALU: accepts one command per Start/Done transaction.

---
 rtl/alu_sequencer_pkg.sv | 30 +++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU front-end sequencer: ALU opcodes, command
// encodings and the sequencer state type.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_LSH = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SUB = 3'd4,
    ALU_RSH = 3'd5,
    ALU_CMP = 3'd6
  } alu_op_e;

  localparam logic [3:0] CMD_MUL = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC      = 3'd1,
    S_MUL_ADD   = 3'd2,
    S_MUL_SHIFT = 3'd3,
    S_DONE      = 3'd4
  } seq_state_e;

  // Opcode 7 has no ALU function, so it is not a legal direct command.
  function automatic logic cmd_is_direct(input logic [3:0] c);
    return (c[3] == 1'b0) && (c[2:0] != 3'd7);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Front-end controller for an external 8-bit ALU: one command per start/done
// transaction; MUL is sequenced as shift-add reusing the ALU adder.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   cmd,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         res_zero,
  output logic         res_par,
  output logic         err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_rslt,
  output seq_state_e   dbg_state
);

  // Handshake: start is a request sampled only in S_IDLE (busy low); done is a
  // one-cycle pulse during which result and flags are valid. start is ignored
  // whenever busy is high, including the done cycle.

  seq_state_e   state, state_next;
  alu_op_e      op_sel;
  logic [W-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic [W-1:0] acc, mcand, mplier;
  logic [W-1:0] mplier_shifted;
  logic         cmd_invalid;

  assign mplier_shifted = mplier >> 1;
  assign cmd_invalid    = !cmd_is_direct(cmd) && (cmd != CMD_MUL);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign alu_op         = op_sel;
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_a      = '0;
    alu_b      = '0;
    op_sel     = ALU_ADD;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cmd_is_direct(cmd))  state_next = S_EXEC;
          else if (cmd == CMD_MUL) state_next = S_MUL_ADD;
          else                     state_next = S_DONE;
        end
      end
      S_EXEC: begin
        alu_a      = a_q;
        alu_b      = b_q;
        op_sel     = alu_op_e'(op_q);
        state_next = S_DONE;
      end
      S_MUL_ADD: begin
        // Skipped partial products leave the ALU at its idle values.
        if (mplier[0]) begin
          alu_a = acc;
          alu_b = mcand;
        end
        state_next = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        state_next = (mplier_shifted == '0) ? S_DONE : S_MUL_ADD;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result   <= '0;
      res_zero <= 1'b1;
      res_par  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= in_a;
            b_q    <= in_b;
            op_q   <= cmd[2:0];
            acc    <= '0;
            mcand  <= in_a;
            mplier <= in_b;
            err    <= cmd_invalid;
            if (cmd_invalid) begin
              result   <= '0;
              res_zero <= 1'b1;
              res_par  <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          result   <= alu_rslt;
          res_zero <= (alu_rslt == '0);
          res_par  <= ^alu_rslt;
        end
        S_MUL_ADD: begin
          if (mplier[0]) acc <= alu_rslt;
        end
        S_MUL_SHIFT: begin
          mcand  <= mcand << 1;
          mplier <= mplier_shifted;
          // High product bits fall off mcand, giving the product mod 2^W.
          if (mplier_shifted == '0) begin
            result   <= acc;
            res_zero <= (acc == '0);
            res_par  <= ^acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU wired to its ALU
// ports; expected values are hand-computed constants.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   cmd;
  logic [W-1:0] in_a, in_b;
  logic         busy, done, res_zero, res_par, err;
  logic [W-1:0] result, alu_a, alu_b, alu_rslt;
  logic [2:0]   alu_op;
  seq_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  int lat;
  bit busy_ok;
  int done_cnt;

  alu_sequencer #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
    .result(result), .res_zero(res_zero), .res_par(res_par), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rslt(alu_rslt),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Behavioural ALU owned by the parent
  always_comb begin
    alu_rslt = '0;
    case (alu_op)
      3'd0: alu_rslt = alu_a + alu_b;
      3'd1: alu_rslt = alu_a << alu_b[2:0];
      3'd2: alu_rslt = alu_a & alu_b;
      3'd3: alu_rslt = alu_a | alu_b;
      3'd4: alu_rslt = alu_a - alu_b;
      3'd5: alu_rslt = alu_a >> alu_b[2:0];
      3'd6: alu_rslt = W'(alu_a < alu_b);
      default: alu_rslt = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and waits (bounded) for done; lat counts cycles from
  // the start edge to the done-high cycle, -1 on timeout.
  task automatic run_cmd(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit interfere, output int lat_o, output bit busy_ok_o);
    @(negedge clk);
    start = 1'b1; cmd = c; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat_o = 1;
    busy_ok_o = 1'b1;
    while (!done && lat_o < 40) begin
      if (!busy) busy_ok_o = 1'b0;
      if (interfere && lat_o >= 2 && lat_o <= 4) begin
        start = 1'b1; cmd = 4'd0; in_a = 8'h77; in_b = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat_o++;
    end
    start = 1'b0;
    if (!done) lat_o = -1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd = '0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_zero", res_zero, 1'b1);
    check("rst_par", res_par, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_alu_op", alu_op, 3'd0);
    check("rst_state", dbg_state, S_IDLE);
    reset = 1'b0;

    // ADD 1+1
    run_cmd(4'd0, 8'd1, 8'd1, 1'b0, lat, busy_ok);
    check("add_lat", lat, 2);
    check("add_res", result, 8'h02);
    check("add_zero", res_zero, 1'b0);
    check("add_par", res_par, 1'b1);
    check("add_err", err, 1'b0);
    check("add_done_busy", busy, 1'b1);

    // AND 4&1 -> zero
    run_cmd(4'd2, 8'd4, 8'd1, 1'b0, lat, busy_ok);
    check("and_res", result, 8'h00);
    check("and_zero", res_zero, 1'b1);

    // SUB 3-5 wraps
    run_cmd(4'd4, 8'd3, 8'd5, 1'b0, lat, busy_ok);
    check("sub_res", result, 8'hFE);
    check("sub_par", res_par, 1'b1);

    // OR with ALU drive observed in EXEC
    @(negedge clk);
    start = 1'b1; cmd = 4'd3; in_a = 8'h50; in_b = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("or_exec_a", alu_a, 8'h50);
    check("or_exec_b", alu_b, 8'h0A);
    check("or_exec_op", alu_op, 3'd3);
    @(negedge clk);
    check("or_done", done, 1'b1);
    check("or_res", result, 8'h5A);
    check("or_par", res_par, 1'b0);
    @(negedge clk);
    check("or_done_pulse", done, 1'b0);
    check("or_idle_alu_a", alu_a, 8'h00);

    // MUL 13*11 = 143, k=3
    run_cmd(CMD_MUL, 8'd13, 8'd11, 1'b0, lat, busy_ok);
    check("mul13_lat", lat, 9);
    check("mul13_res", result, 8'h8F);
    check("mul13_busy", busy_ok, 1'b1);
    check("mul13_par", res_par, 1'b1);
    @(negedge clk);
    check("mul13_done_pulse", done, 1'b0);
    check("mul13_idle", busy, 1'b0);

    // MUL 16*16 wraps to 0, k=4
    run_cmd(CMD_MUL, 8'd16, 8'd16, 1'b0, lat, busy_ok);
    check("mul16_lat", lat, 11);
    check("mul16_res", result, 8'h00);
    check("mul16_zero", res_zero, 1'b1);

    // MUL by zero
    run_cmd(CMD_MUL, 8'd200, 8'd0, 1'b0, lat, busy_ok);
    check("mul0_lat", lat, 3);
    check("mul0_res", result, 8'h00);

    // MUL 255*255 = 65025 -> 0x01, k=7
    run_cmd(CMD_MUL, 8'hFF, 8'hFF, 1'b0, lat, busy_ok);
    check("mulff_lat", lat, 17);
    check("mulff_res", result, 8'h01);
    check("mulff_zero", res_zero, 1'b0);

    // start re-asserted mid-MUL is ignored
    run_cmd(CMD_MUL, 8'd13, 8'd11, 1'b1, lat, busy_ok);
    check("intf_lat", lat, 9);
    check("intf_res", result, 8'h8F);
    check("intf_err", err, 1'b0);

    // Invalid commands
    run_cmd(4'b1010, 8'd9, 8'd9, 1'b0, lat, busy_ok);
    check("inv_lat", lat, 1);
    check("inv_err", err, 1'b1);
    check("inv_res", result, 8'h00);
    check("inv_zero", res_zero, 1'b1);
    run_cmd(4'd7, 8'd9, 8'd9, 1'b0, lat, busy_ok);
    check("inv7_lat", lat, 1);
    check("inv7_err", err, 1'b1);

    // Valid command clears err; leaves nonzero result before the reset test
    run_cmd(4'd0, 8'd7, 8'd8, 1'b0, lat, busy_ok);
    check("clr_err", err, 1'b0);
    check("clr_res", result, 8'h0F);

    // Async reset mid-MUL
    @(negedge clk);
    start = 1'b1; cmd = CMD_MUL; in_a = 8'd13; in_b = 8'd11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_result", result, 8'h00);
    check("arst_done", done, 1'b0);
    check("arst_state", dbg_state, S_IDLE);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("arst_no_done", done_cnt, 0);
    run_cmd(4'd0, 8'd2, 8'd3, 1'b0, lat, busy_ok);
    check("post_lat", lat, 2);
    check("post_res", result, 8'h05);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
